// File: rtl/decode_scoreboard_rf_pkg.sv
// Shared definitions for the decode-stage register file and scoreboard:
// NZP encodings and the condition-code derivation from writeback data.
package decode_scoreboard_rf_pkg;

  localparam logic [2:0] CC_N   = 3'b100;
  localparam logic [2:0] CC_Z   = 3'b010;
  localparam logic [2:0] CC_P   = 3'b001;
  localparam logic [2:0] CC_RST = CC_Z;

  // Widest register the NZP helper accepts; narrower data is zero-extended.
  localparam int MAX_DATA_W = 64;

  function automatic logic [2:0] cc_from_data(input logic [MAX_DATA_W-1:0] data,
                                              input int unsigned            width);
    logic [5:0] sign_bit;
    sign_bit = 6'(width - 1);
    if (data[sign_bit])   return CC_N;
    else if (data == '0)  return CC_Z;
    else                  return CC_P;
  endfunction

endpackage

// File: rtl/decode_scoreboard_rf_if.sv
// Decode/writeback/cancel bundle between the decode stage and the register file scoreboard.
interface decode_scoreboard_rf_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4,
  parameter int NUM_WB = 2
);
  logic                     I_IssueValid;
  logic                     I_Src1Use;
  logic [IDX_W-1:0]         I_Src1Idx;
  logic                     I_Src2Use;
  logic [IDX_W-1:0]         I_Src2Idx;
  logic                     I_DestUse;
  logic [IDX_W-1:0]         I_DestIdx;
  logic                     I_SetsCC;
  logic                     I_CCUse;
  logic [NUM_WB-1:0]        I_WbEnable;
  logic [NUM_WB*IDX_W-1:0]  I_WbIdx;
  logic [NUM_WB*DATA_W-1:0] I_WbData;
  logic [NUM_WB-1:0]        I_WbSetCC;
  logic                     I_Cancel;
  logic [IDX_W-1:0]         I_CancelIdx;
  logic                     I_CancelCC;
  logic                     O_Stall;
  logic                     O_Issued;
  logic [DATA_W-1:0]        O_Src1Value;
  logic [DATA_W-1:0]        O_Src2Value;
  logic [2:0]               O_CC;
  logic                     O_SbError;

  modport master (
    output I_IssueValid, I_Src1Use, I_Src1Idx, I_Src2Use, I_Src2Idx, I_DestUse, I_DestIdx,
           I_SetsCC, I_CCUse, I_WbEnable, I_WbIdx, I_WbData, I_WbSetCC,
           I_Cancel, I_CancelIdx, I_CancelCC,
    input  O_Stall, O_Issued, O_Src1Value, O_Src2Value, O_CC, O_SbError
  );

  modport slave (
    input  I_IssueValid, I_Src1Use, I_Src1Idx, I_Src2Use, I_Src2Idx, I_DestUse, I_DestIdx,
           I_SetsCC, I_CCUse, I_WbEnable, I_WbIdx, I_WbData, I_WbSetCC,
           I_Cancel, I_CancelIdx, I_CancelCC,
    output O_Stall, O_Issued, O_Src1Value, O_Src2Value, O_CC, O_SbError
  );
endinterface

// File: rtl/decode_scoreboard_rf_pending_counter.sv
// Saturating outstanding-write counter: one increment and up to 2**DEC_W-1 decrements per
// cycle, net change applied at once; err_o flags an attempted underflow or overflow.
module sb_pending_counter #(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic [DEC_W-1:0] dec_i,
  output logic             zero_o,
  output logic             one_o,
  output logic             max_o,
  output logic             err_o
);

  localparam int W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     up, dn;

  always_comb begin
    up    = W'(cnt_q) + W'(inc_i);
    dn    = W'(dec_i);
    cnt_d = cnt_q;
    err_o = 1'b0;
    if (up < dn) begin
      cnt_d = '0;
      err_o = 1'b1;
    end else if ((up - dn) > W'(MAX)) begin
      cnt_d = MAX;
      err_o = 1'b1;
    end else begin
      cnt_d = CNT_W'(up - dn);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == CNT_W'(1));
  assign max_o  = (cnt_q == MAX);

endmodule

// File: rtl/decode_scoreboard_rf.sv
// Decode-stage register file with counting scoreboard, writeback bypass, NZP tracking,
// squash cancellation and the issue stall toward fetch.
module decode_scoreboard_rf
  import decode_scoreboard_rf_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4,
  parameter int NUM_WB   = 2,
  parameter int CNT_W    = 2
) (
  input  logic                 I_CLOCK,
  input  logic                 I_RESET_N,
  decode_scoreboard_rf_if.slave bus
);

  localparam int DEC_W   = $clog2(NUM_WB + 2);
  localparam int NCNT    = NUM_REGS + 1;
  localparam int CC_SLOT = NUM_REGS;

  logic [NUM_WB-1:0][IDX_W-1:0]   wb_idx;
  logic [NUM_WB-1:0][DATA_W-1:0]  wb_data;
  logic [NUM_WB-1:0]              wb_cc;
  logic [2**IDX_W-1:0]            idx_ok;

  logic [NUM_REGS-1:0][DATA_W-1:0] rf_q, rf_d;
  logic [2:0]                      cc_q, cc_d;
  logic                            issued_q, sberr_q;
  logic [DATA_W-1:0]               src1_q, src2_q;

  logic [NCNT-1:0] cnt_zero, cnt_one, cnt_max, cnt_err;

  logic [1:0][IDX_W-1:0]  src_idx;
  logic [1:0][DATA_W-1:0] src_val;
  logic [1:0]             src_byp, src_hit;
  logic                   dest_full, cc_block, stall, accept;

  assign wb_idx  = bus.I_WbIdx;
  assign wb_data = bus.I_WbData;
  assign wb_cc   = bus.I_WbEnable & bus.I_WbSetCC;
  assign src_idx = {bus.I_Src2Idx, bus.I_Src1Idx};

  // Indices at or beyond NUM_REGS have no storage and no counter.
  for (genvar i = 0; i < 2**IDX_W; i++) begin : g_ok
    assign idx_ok[i] = (i < NUM_REGS);
  end

  // Ascending port scan leaves the highest matching port as the bypass source.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_val[s] = '0;
      src_byp[s] = 1'b0;
      if (idx_ok[src_idx[s]]) src_val[s] = rf_q[src_idx[s]];
      for (int p = 0; p < NUM_WB; p++) begin
        if (bus.I_WbEnable[p] && (wb_idx[p] == src_idx[s]) && idx_ok[src_idx[s]]) begin
          src_val[s] = wb_data[p];
          src_byp[s] = 1'b1;
        end
      end
      src_hit[s] = !idx_ok[src_idx[s]] || cnt_zero[src_idx[s]] ||
                   (cnt_one[src_idx[s]] && src_byp[s]);
    end
  end

  assign dest_full = idx_ok[bus.I_DestIdx] && cnt_max[bus.I_DestIdx];
  assign cc_block  = !cnt_zero[CC_SLOT] && !(cnt_one[CC_SLOT] && (|wb_cc));

  assign stall  = bus.I_IssueValid &&
                  ((bus.I_Src1Use && !src_hit[0]) ||
                   (bus.I_Src2Use && !src_hit[1]) ||
                   (bus.I_DestUse && dest_full)   ||
                   (bus.I_CCUse   && cc_block)    ||
                   (bus.I_SetsCC  && cnt_max[CC_SLOT]));
  assign accept = bus.I_IssueValid && !stall;

  for (genvar r = 0; r < NCNT; r++) begin : g_cnt
    logic             inc;
    logic [DEC_W-1:0] dec;

    if (r == CC_SLOT) begin : g_cc
      assign inc = accept && bus.I_SetsCC;
      always_comb begin
        dec = '0;
        for (int p = 0; p < NUM_WB; p++)
          if (wb_cc[p]) dec = dec + DEC_W'(1);
        if (bus.I_Cancel && bus.I_CancelCC) dec = dec + DEC_W'(1);
      end
    end else begin : g_reg
      assign inc = accept && bus.I_DestUse && (bus.I_DestIdx == IDX_W'(r));
      always_comb begin
        dec = '0;
        for (int p = 0; p < NUM_WB; p++)
          if (bus.I_WbEnable[p] && (wb_idx[p] == IDX_W'(r))) dec = dec + DEC_W'(1);
        if (bus.I_Cancel && (bus.I_CancelIdx == IDX_W'(r))) dec = dec + DEC_W'(1);
      end
    end

    sb_pending_counter #(.CNT_W(CNT_W), .DEC_W(DEC_W)) u_cnt (
      .clk_i  (I_CLOCK),
      .rst_ni (I_RESET_N),
      .inc_i  (inc),
      .dec_i  (dec),
      .zero_o (cnt_zero[r]),
      .one_o  (cnt_one[r]),
      .max_o  (cnt_max[r]),
      .err_o  (cnt_err[r])
    );
  end

  always_comb begin
    rf_d = rf_q;
    cc_d = cc_q;
    for (int p = 0; p < NUM_WB; p++) begin
      if (bus.I_WbEnable[p] && idx_ok[wb_idx[p]]) rf_d[wb_idx[p]] = wb_data[p];
      if (wb_cc[p]) cc_d = cc_from_data(MAX_DATA_W'(wb_data[p]), unsigned'(DATA_W));
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      rf_q     <= '0;
      cc_q     <= CC_RST;
      issued_q <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      sberr_q  <= 1'b0;
    end else begin
      rf_q     <= rf_d;
      cc_q     <= cc_d;
      issued_q <= accept;
      sberr_q  <= sberr_q | (|cnt_err);
      if (accept) begin
        src1_q <= src_val[0];
        src2_q <= src_val[1];
      end
    end
  end

  assign bus.O_Stall     = stall;
  assign bus.O_Issued    = issued_q;
  assign bus.O_Src1Value = src1_q;
  assign bus.O_Src2Value = src2_q;
  assign bus.O_CC        = cc_q;
  assign bus.O_SbError   = sberr_q;

endmodule

// File: tb/tb_decode_scoreboard_rf.sv
// Scenario bench for decode_scoreboard_rf: expected operands are queued at issue and
// popped when O_Issued reports the accepted instruction.
module tb_decode_scoreboard_rf;

  localparam int DW = 16, NR = 16, IW = 4, NWB = 2, CW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  decode_scoreboard_rf_if #(.DATA_W(DW), .IDX_W(IW), .NUM_WB(NWB)) bus ();

  decode_scoreboard_rf #(.DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW), .NUM_WB(NWB), .CNT_W(CW)) dut (
    .I_CLOCK   (clk),
    .I_RESET_N (rst_n),
    .bus       (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [15:0] rf_m[NR];

  task automatic idle();
    bus.I_IssueValid = 0; bus.I_Src1Use = 0; bus.I_Src1Idx = 0; bus.I_Src2Use = 0;
    bus.I_Src2Idx = 0; bus.I_DestUse = 0; bus.I_DestIdx = 0; bus.I_SetsCC = 0; bus.I_CCUse = 0;
    bus.I_WbEnable = 0; bus.I_WbIdx = 0; bus.I_WbData = 0; bus.I_WbSetCC = 0;
    bus.I_Cancel = 0; bus.I_CancelIdx = 0; bus.I_CancelCC = 0;
  endtask

  task automatic issue(input logic s1u, input logic [3:0] s1, input logic s2u, input logic [3:0] s2,
                       input logic du, input logic [3:0] d, input logic scc, input logic ccu);
    bus.I_IssueValid = 1; bus.I_Src1Use = s1u; bus.I_Src1Idx = s1; bus.I_Src2Use = s2u;
    bus.I_Src2Idx = s2; bus.I_DestUse = du; bus.I_DestIdx = d; bus.I_SetsCC = scc; bus.I_CCUse = ccu;
  endtask

  task automatic wb(input int p, input logic [3:0] idx, input logic [15:0] data, input logic scc);
    bus.I_WbEnable[p] = 1'b1;
    bus.I_WbIdx[p*IW +: IW] = idx;
    bus.I_WbData[p*DW +: DW] = data;
    bus.I_WbSetCC[p] = scc;
  endtask

  // Reference register contents follow the writebacks presented this cycle, highest port last.
  task automatic tick();
    logic [3:0] idx;
    for (int p = 0; p < NWB; p++) begin
      idx = bus.I_WbIdx[p*IW +: IW];
      if (bus.I_WbEnable[p] && rst_n && int'(idx) < NR) rf_m[idx] = bus.I_WbData[p*DW +: DW];
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus.O_Issued !== 1'b0) begin n_err++; $display("FAIL reset_issued: got %b want 0", bus.O_Issued); end
    n_vec++; if ({bus.O_Src1Value, bus.O_Src2Value} !== 32'h0) begin n_err++; $display("FAIL reset_src: got %h want 0", {bus.O_Src1Value, bus.O_Src2Value}); end
    n_vec++; if (bus.O_CC !== 3'b010) begin n_err++; $display("FAIL reset_cc: got %b want 010", bus.O_CC); end
    n_vec++; if (bus.O_SbError !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.O_SbError); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus.O_Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.O_Stall); end
  endtask

  task automatic test_raw();
    logic [31:0] e;
    issue(0, 0, 0, 0, 1, 2, 0, 0); #1;
    n_vec++; if (bus.O_Stall !== 1'b0) begin n_err++; $display("FAIL raw_dest_stall: got %b want 0", bus.O_Stall); end
    exp_q.push_back({rf_m[0], rf_m[0]}); tick();
    n_vec++; if (bus.O_Issued !== 1'b1) begin n_err++; $display("FAIL raw_dest_issued: got %b want 1", bus.O_Issued); end
    else begin e = exp_q.pop_front(); n_vec++; if ({bus.O_Src1Value, bus.O_Src2Value} !== e) begin n_err++; $display("FAIL raw_dest_ops: got %h want %h", {bus.O_Src1Value, bus.O_Src2Value}, e); end end
    issue(1, 2, 0, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.O_Stall !== 1'b1) begin n_err++; $display("FAIL raw_read_stall: got %b want 1", bus.O_Stall); end
    tick();
    n_vec++; if (bus.O_Issued !== 1'b0) begin n_err++; $display("FAIL raw_read_held: got %b want 0", bus.O_Issued); end
    issue(1, 2, 0, 0, 0, 0, 0, 0); wb(0, 2, 16'h0005, 0); #1;
    n_vec++; if (bus.O_Stall !== 1'b0) begin n_err++; $display("FAIL raw_bypass_stall: got %b want 0", bus.O_Stall); end
    exp_q.push_back({16'h0005, 16'h0000}); tick();
    n_vec++; if (bus.O_Issued !== 1'b1) begin n_err++; $display("FAIL raw_bypass_issued: got %b want 1", bus.O_Issued); end
    else begin e = exp_q.pop_front(); n_vec++; if ({bus.O_Src1Value, bus.O_Src2Value} !== e) begin n_err++; $display("FAIL raw_bypass_ops: got %h want %h", {bus.O_Src1Value, bus.O_Src2Value}, e); end end
  endtask

  task automatic test_waw();
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      issue(0, 0, 0, 0, 1, 4, 0, 0); #1;
      n_vec++; if (bus.O_Stall !== 1'b0) begin n_err++; $display("FAIL waw_claim%0d_stall: got %b want 0", i, bus.O_Stall); end
      exp_q.push_back({rf_m[0], rf_m[0]}); tick();
      n_vec++; if (bus.O_Issued !== 1'b1) begin n_err++; $display("FAIL waw_claim%0d_issued: got %b want 1", i, bus.O_Issued); end
      else begin e = exp_q.pop_front(); n_vec++; if ({bus.O_Src1Value, bus.O_Src2Value} !== e) begin n_err++; $display("FAIL waw_claim%0d_ops: got %h want %h", i, {bus.O_Src1Value, bus.O_Src2Value}, e); end end
    end
    issue(0, 0, 0, 0, 1, 4, 0, 0); #1;
    n_vec++; if (bus.O_Stall !== 1'b1) begin n_err++; $display("FAIL waw_full_stall: got %b want 1", bus.O_Stall); end
    tick();
    wb(0, 4, 16'h0044, 0); tick();                       // pend 3 -> 2
    issue(1, 4, 0, 0, 0, 0, 0, 0); wb(0, 4, 16'h0045, 0); #1;
    n_vec++; if (bus.O_Stall !== 1'b1) begin n_err++; $display("FAIL waw_pend2_stall: got %b want 1", bus.O_Stall); end
    tick();                                              // pend 2 -> 1
    issue(1, 4, 0, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.O_Stall !== 1'b1) begin n_err++; $display("FAIL waw_pend1_stall: got %b want 1", bus.O_Stall); end
    tick();
    issue(1, 4, 0, 0, 0, 0, 0, 0); wb(1, 4, 16'h0046, 0); #1;
    n_vec++; if (bus.O_Stall !== 1'b0) begin n_err++; $display("FAIL waw_last_stall: got %b want 0", bus.O_Stall); end
    exp_q.push_back({16'h0046, 16'h0000}); tick();
    n_vec++; if (bus.O_Issued !== 1'b1) begin n_err++; $display("FAIL waw_last_issued: got %b want 1", bus.O_Issued); end
    else begin e = exp_q.pop_front(); n_vec++; if ({bus.O_Src1Value, bus.O_Src2Value} !== e) begin n_err++; $display("FAIL waw_last_ops: got %h want %h", {bus.O_Src1Value, bus.O_Src2Value}, e); end end
  endtask

  task automatic test_dual_wb();
    logic [31:0] e;
    issue(0, 0, 0, 0, 1, 5, 0, 0); tick();
    issue(0, 0, 0, 0, 1, 5, 0, 0); tick();
    exp_q.delete();
    wb(0, 5, 16'h0011, 0); wb(1, 5, 16'h0022, 0); tick();
    issue(0, 0, 1, 5, 0, 0, 0, 0); #1;
    n_vec++; if (bus.O_Stall !== 1'b0) begin n_err++; $display("FAIL dual_stall: got %b want 0", bus.O_Stall); end
    exp_q.push_back({16'h0000, 16'h0022}); tick();
    n_vec++; if (bus.O_Issued !== 1'b1) begin n_err++; $display("FAIL dual_issued: got %b want 1", bus.O_Issued); end
    else begin e = exp_q.pop_front(); n_vec++; if ({bus.O_Src1Value, bus.O_Src2Value} !== e) begin n_err++; $display("FAIL dual_ops: got %h want %h", {bus.O_Src1Value, bus.O_Src2Value}, e); end end
  endtask

  task automatic test_cc();
    logic [31:0] e;
    issue(0, 0, 0, 0, 1, 7, 1, 0); tick();
    issue(0, 0, 0, 0, 1, 7, 1, 0); tick();
    exp_q.delete();
    issue(0, 0, 0, 0, 0, 0, 0, 1); #1;
    n_vec++; if (bus.O_Stall !== 1'b1) begin n_err++; $display("FAIL cc_pend2_stall: got %b want 1", bus.O_Stall); end
    tick();
    wb(0, 7, 16'h8000, 1); tick();
    n_vec++; if (bus.O_CC !== 3'b100) begin n_err++; $display("FAIL cc_neg: got %b want 100", bus.O_CC); end
    issue(0, 0, 0, 0, 0, 0, 0, 1); #1;
    n_vec++; if (bus.O_Stall !== 1'b1) begin n_err++; $display("FAIL cc_pend1_stall: got %b want 1", bus.O_Stall); end
    tick();
    issue(0, 0, 0, 0, 0, 0, 0, 1); wb(1, 7, 16'h0000, 1); #1;
    n_vec++; if (bus.O_Stall !== 1'b0) begin n_err++; $display("FAIL cc_bypass_stall: got %b want 0", bus.O_Stall); end
    exp_q.push_back({rf_m[0], rf_m[0]}); tick();
    n_vec++; if (bus.O_CC !== 3'b010) begin n_err++; $display("FAIL cc_zero: got %b want 010", bus.O_CC); end
    n_vec++; if (bus.O_Issued !== 1'b1) begin n_err++; $display("FAIL cc_branch_issued: got %b want 1", bus.O_Issued); end
    else begin e = exp_q.pop_front(); n_vec++; if ({bus.O_Src1Value, bus.O_Src2Value} !== e) begin n_err++; $display("FAIL cc_branch_ops: got %h want %h", {bus.O_Src1Value, bus.O_Src2Value}, e); end end
    issue(0, 0, 0, 0, 1, 8, 1, 0); tick();
    exp_q.delete();
    wb(0, 8, 16'h0123, 1); tick();
    n_vec++; if (bus.O_CC !== 3'b001) begin n_err++; $display("FAIL cc_pos: got %b want 001", bus.O_CC); end
    n_vec++; if (bus.O_SbError !== 1'b0) begin n_err++; $display("FAIL cc_err_clean: got %b want 0", bus.O_SbError); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  s1_t[8] = '{4'd2, 4'd4, 4'd5, 4'd7, 4'd8, 4'd0, 4'd2, 4'd5};
    logic [3:0]  s2_t[8] = '{4'd5, 4'd8, 4'd2, 4'd4, 4'd0, 4'd7, 4'd4, 4'd2};
    logic [31:0] e;
    for (int i = 0; i < 8; i++) begin
      issue(1, s1_t[i], 1, s2_t[i], 0, 0, 0, 0); #1;
      n_vec++; if (bus.O_Stall !== 1'b0) begin n_err++; $display("FAIL b2b%0d_stall: got %b want 0", i, bus.O_Stall); end
      exp_q.push_back({rf_m[s1_t[i]], rf_m[s2_t[i]]}); tick();
      n_vec++; if (bus.O_Issued !== 1'b1) begin n_err++; $display("FAIL b2b%0d_issued: got %b want 1", i, bus.O_Issued); end
      else begin e = exp_q.pop_front(); n_vec++; if ({bus.O_Src1Value, bus.O_Src2Value} !== e) begin n_err++; $display("FAIL b2b%0d_ops: got %h want %h", i, {bus.O_Src1Value, bus.O_Src2Value}, e); end end
    end
  endtask

  task automatic test_cancel();
    logic [31:0] e;
    issue(0, 0, 0, 0, 1, 6, 0, 0); tick();
    exp_q.delete();
    issue(1, 6, 0, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.O_Stall !== 1'b1) begin n_err++; $display("FAIL cancel_pre_stall: got %b want 1", bus.O_Stall); end
    tick();
    bus.I_Cancel = 1'b1; bus.I_CancelIdx = 4'd6; tick();
    issue(1, 6, 0, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.O_Stall !== 1'b0) begin n_err++; $display("FAIL cancel_post_stall: got %b want 0", bus.O_Stall); end
    exp_q.push_back({16'h0000, 16'h0000}); tick();
    n_vec++; if (bus.O_Issued !== 1'b1) begin n_err++; $display("FAIL cancel_issued: got %b want 1", bus.O_Issued); end
    else begin e = exp_q.pop_front(); n_vec++; if ({bus.O_Src1Value, bus.O_Src2Value} !== e) begin n_err++; $display("FAIL cancel_ops: got %h want %h", {bus.O_Src1Value, bus.O_Src2Value}, e); end end
    n_vec++; if (bus.O_SbError !== 1'b0) begin n_err++; $display("FAIL cancel_err_early: got %b want 0", bus.O_SbError); end
    bus.I_Cancel = 1'b1; bus.I_CancelIdx = 4'd6; tick();
    n_vec++; if (bus.O_SbError !== 1'b1) begin n_err++; $display("FAIL cancel_underflow: got %b want 1", bus.O_SbError); end
    repeat (3) tick();
    n_vec++; if (bus.O_SbError !== 1'b1) begin n_err++; $display("FAIL cancel_sticky: got %b want 1", bus.O_SbError); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    issue(0, 0, 0, 0, 1, 3, 0, 0); tick();
    wb(0, 3, 16'h0077, 0); tick();
    issue(0, 0, 0, 0, 1, 3, 1, 0); tick();
    exp_q.delete();
    rst_n = 1'b0; #2;
    n_vec++; if (bus.O_Issued !== 1'b0) begin n_err++; $display("FAIL mid_reset_issued: got %b want 0", bus.O_Issued); end
    n_vec++; if ({bus.O_Src1Value, bus.O_Src2Value} !== 32'h0) begin n_err++; $display("FAIL mid_reset_src: got %h want 0", {bus.O_Src1Value, bus.O_Src2Value}); end
    n_vec++; if (bus.O_CC !== 3'b010) begin n_err++; $display("FAIL mid_reset_cc: got %b want 010", bus.O_CC); end
    n_vec++; if (bus.O_SbError !== 1'b0) begin n_err++; $display("FAIL mid_reset_err: got %b want 0", bus.O_SbError); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) rf_m[i] = '0;
    issue(1, 3, 0, 0, 0, 0, 0, 1); #1;
    n_vec++; if (bus.O_Stall !== 1'b0) begin n_err++; $display("FAIL mid_reset_stall: got %b want 0", bus.O_Stall); end
    exp_q.push_back({16'h0000, 16'h0000}); tick();
    n_vec++; if (bus.O_Issued !== 1'b1) begin n_err++; $display("FAIL mid_reset_read_issued: got %b want 1", bus.O_Issued); end
    else begin e = exp_q.pop_front(); n_vec++; if ({bus.O_Src1Value, bus.O_Src2Value} !== e) begin n_err++; $display("FAIL mid_reset_read_ops: got %h want %h", {bus.O_Src1Value, bus.O_Src2Value}, e); end end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) rf_m[i] = '0;
    test_reset();
    test_raw();
    test_waw();
    test_dual_wb();
    test_cc();
    test_back_to_back();
    test_cancel();
    test_reset_mid();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL queue_drain: %0d left want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
